// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor.
// A single full-adder cell is reused over WIDTH cycles, LSB first, to form
// a+b or a-b (as a + ~b + 1). It has a start/busy/done handshake and
// reports carry, signed overflow and zero flags with the result.
module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_last;
    logic w_sum;
    logic w_carry;

    // A start only counts when no operation is running.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // One full-adder cell on the current LSBs.
    assign w_sum   = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_carry = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: DONE behaves like IDLE for a new start, so
    // back-to-back operations have no gap.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: load operands on accept, then shift one bit per RUN cycle.
    // Subtraction inverts b at load time and seeds the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_carry;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                // Signed overflow: carry into the MSB differs from carry out.
                r_cout <= w_carry;
                r_ovf  <= r_carry ^ w_carry;
            end
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = (r_result == '0);

endmodule
